// File: rtl/fp32_mult_arbiter_if.sv
// Request, multiplier and response signals of fp32_mult_arbiter.
// The master modport is the surrounding system and the slave modport is the arbiter.
interface fp32_mult_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  mul_in_valid;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic                  mul_out_valid;
  logic [31:0]           mul_result;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_ready;
  logic                  err_flag;

  modport master (
    output req_valid, req_a, req_b, mul_out_valid, mul_result, rsp_ready,
    input  req_ready, mul_in_valid, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, err_flag
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_out_valid, mul_result, rsp_ready,
    output req_ready, mul_in_valid, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, err_flag
  );
endinterface

// File: rtl/fp32_mult_arbiter.sv
// Round-robin sharing of one pipelined FP32 multiplier with a credit-guarded response FIFO.
// Define FP_ZERO_BYPASS_EN to skip issuing operations that have a zero or denormal operand.
module fp32_mult_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 4,
  parameter int RSP_DEPTH   = 8
) (
  input logic                clk,
  input logic                rstn,
  fp32_mult_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = PW + 1;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
`ifdef FP_ZERO_BYPASS_EN
    logic           bypass;
    logic           sign;
`endif
  } tag_t;

  logic [IDW-1:0] last_grant_q;
  logic [CW-1:0]  credit_q, credit_d;
  logic           mul_in_valid_q;
  logic [31:0]    mul_a_q, mul_b_q;
  tag_t           issue_tag_q;
  tag_t           tag_q [MUL_LATENCY];
  logic [CW-1:0]  wr_ptr_q, rd_ptr_q;
  logic           err_q;
  logic [IDW-1:0] fifo_id_mem   [RSP_DEPTH];
  logic [31:0]    fifo_data_mem [RSP_DEPTH];

  logic           found, can_grant, accept, pop, skip_issue;
  logic           rsp_valid, fifo_we, exp_mul_valid;
  logic [IDW-1:0] gnt_id;
  logic [31:0]    sel_a, sel_b, fifo_wdata;
  tag_t           new_tag, tag_out;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // NOTE: combinational logic uses blocking '=' so later statements see earlier results.
  always_comb begin
    // NOTE: every variable gets a default before the search, otherwise a latch is inferred.
    found  = 1'b0;
    gnt_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && bus.req_valid[wrap_idx(last_grant_q, k)]) begin
        found  = 1'b1;
        gnt_id = wrap_idx(last_grant_q, k);
      end
    end
  end

  // Reset also gates the grant so nothing is accepted while rstn is low.
  assign can_grant     = rstn && (credit_q < CW'(RSP_DEPTH));
  assign accept        = found && can_grant;
  assign bus.req_ready = accept ? (NUM_REQ'(1) << gnt_id) : '0;
  assign sel_a         = bus.req_a[int'(gnt_id)*32 +: 32];
  assign sel_b         = bus.req_b[int'(gnt_id)*32 +: 32];
  assign tag_out       = tag_q[MUL_LATENCY-1];
  assign fifo_we       = tag_out.valid;
  assign rsp_valid     = (wr_ptr_q != rd_ptr_q);
  assign pop           = rsp_valid && bus.rsp_ready;

`ifdef FP_ZERO_BYPASS_EN
  assign skip_issue    = (sel_a[30:23] == 8'd0) || (sel_b[30:23] == 8'd0);
  assign new_tag       = '{valid: accept, id: gnt_id, bypass: skip_issue, sign: sel_a[31] ^ sel_b[31]};
  assign exp_mul_valid = tag_out.valid && !tag_out.bypass;
  assign fifo_wdata    = tag_out.bypass ? {tag_out.sign, 31'b0} : bus.mul_result;
`else
  assign skip_issue    = 1'b0;
  assign new_tag       = '{valid: accept, id: gnt_id};
  assign exp_mul_valid = tag_out.valid;
  assign fifo_wdata    = bus.mul_result;
`endif

  always_comb begin
    credit_d = credit_q;
    if (accept && !pop)      credit_d = credit_q + CW'(1);
    else if (!accept && pop) credit_d = credit_q - CW'(1);
  end

  // NOTE: all registered state uses non-blocking '<=' so each flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_grant_q   <= IDW'(NUM_REQ - 1);
      credit_q       <= '0;
      mul_in_valid_q <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      issue_tag_q    <= '0;
      for (int i = 0; i < MUL_LATENCY; i++) tag_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      err_q          <= 1'b0;
    end else begin
      credit_q       <= credit_d;
      mul_in_valid_q <= accept && !skip_issue;
      issue_tag_q    <= new_tag;
      tag_q[0]       <= issue_tag_q;
      for (int i = 1; i < MUL_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (accept) begin
        last_grant_q <= gnt_id;
        mul_a_q      <= skip_issue ? 32'd0 : sel_a;
        mul_b_q      <= skip_issue ? 32'd0 : sel_b;
      end
      if (fifo_we) wr_ptr_q <= wr_ptr_q + CW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + CW'(1);
      if (exp_mul_valid != bus.mul_out_valid) err_q <= 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; only the reset pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (fifo_we) begin
      fifo_id_mem[wr_ptr_q[PW-1:0]]   <= tag_out.id;
      fifo_data_mem[wr_ptr_q[PW-1:0]] <= fifo_wdata;
    end
  end

  assign bus.mul_in_valid = mul_in_valid_q;
  assign bus.mul_a        = mul_a_q;
  assign bus.mul_b        = mul_b_q;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_id       = rsp_valid ? fifo_id_mem[rd_ptr_q[PW-1:0]] : '0;
  assign bus.rsp_data     = rsp_valid ? fifo_data_mem[rd_ptr_q[PW-1:0]] : '0;
  assign bus.err_flag     = err_q;
endmodule

// File: tb/tb_fp32_mult_arbiter.sv
// Bench for fp32_mult_arbiter: multiplier model, response scoreboard and directed scenarios.
// Honours FP_ZERO_BYPASS_EN to add the zero-operand bypass scenario.
module tb_fp32_mult_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int MUL_LATENCY = 4;
  localparam int RSP_DEPTH   = 8;

  typedef struct {
    int          id;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        inj = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          issue_cnt = 0;
  rsp_t        sb[$];
  int          gnt_log[$];
  logic [32:0] mstage [MUL_LATENCY+1];

  fp32_mult_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  fp32_mult_arbiter #(
    .NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Stand-in product: exact for the 1.5*2.0 case, a fixed mixing function otherwise.
  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h13579BDF;
  endfunction

  function automatic logic [31:0] exp_rsp(input logic [31:0] a, input logic [31:0] b);
`ifdef FP_ZERO_BYPASS_EN
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'b0};
`endif
    return mul_model(a, b);
  endfunction

  // Pipelined multiplier: issue seen in cycle T+1 comes back in cycle T+1+MUL_LATENCY.
  initial begin
    for (int i = 0; i <= MUL_LATENCY; i++) mstage[i] = '0;
    bus.mul_out_valid = 1'b0;
    bus.mul_result    = '0;
    forever begin
      @(negedge clk);
      for (int i = MUL_LATENCY; i > 0; i--) mstage[i] = mstage[i-1];
      mstage[0]         = {bus.mul_in_valid, mul_model(bus.mul_a, bus.mul_b)};
      bus.mul_out_valid = mstage[MUL_LATENCY][32] | inj;
      bus.mul_result    = mstage[MUL_LATENCY][31:0];
      inj               = 1'b0;
    end
  end

  // Scoreboard: push on accept, pop and compare on response handshake.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.mul_in_valid) issue_cnt++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb.push_back('{id: i, data: exp_rsp(bus.req_a[32*i +: 32], bus.req_b[32*i +: 32])});
          gnt_log.push_back(i);
          acc_cnt++;
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 32'(bus.rsp_id), e.id);
          chk("rsp_data", bus.rsp_data, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, $urandom() | 32'h00800000, $urandom() | 32'h00800000);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    while ((sb.size() != 0 || bus.rsp_valid) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_req_ready"}, 32'(bus.req_ready), 0);
    chk({pfx, "_mul_in_valid"}, 32'(bus.mul_in_valid), 0);
    chk({pfx, "_mul_a"}, bus.mul_a, 0);
    chk({pfx, "_mul_b"}, bus.mul_b, 0);
    chk({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({pfx, "_rsp_id"}, 32'(bus.rsp_id), 0);
    chk({pfx, "_rsp_data"}, bus.rsp_data, 0);
    chk({pfx, "_err_flag"}, 32'(bus.err_flag), 0);
  endtask

  initial begin
    int t_acc, n, acc0, iss0;
    logic saw;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    rstn          = 1'b0;
    repeat (3) tick();
    bus.req_valid = '1;
    @(negedge clk);
    check_all_zero("reset");
    tick();
    bus.req_valid = '0;
    rstn = 1'b1;
    tick();

    // Single 1.5 * 2.0 request and its latency.
    bus.rsp_ready = 1'b1;
    set_ops(0, 32'h3FC00000, 32'h40000000);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_grant", 32'(bus.req_ready), 32'h1);
    t_acc = cyc;
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t1_issue_valid", 32'(bus.mul_in_valid), 1);
    chk("t1_mul_a", bus.mul_a, 32'h3FC00000);
    chk("t1_mul_b", bus.mul_b, 32'h40000000);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t1_latency", cyc - t_acc, MUL_LATENCY + 2);
    drain("t1_drain");

    // All requesters streaming; last grant was 0 so the rotation starts at 1.
    gnt_log.delete();
    iss0 = issue_cnt;
    bus.req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      rand_ops();
      tick();
    end
    drain("rr_drain");
    chk("rr_grants", gnt_log.size(), 12);
    for (int k = 0; k < 12 && k < gnt_log.size(); k++) chk("rr_order", gnt_log[k], (k + 1) % NUM_REQ);
    chk("rr_issues", issue_cnt - iss0, 12);

    // Backpressure: credits cap accepts at RSP_DEPTH, one pop buys exactly one more.
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    acc0 = acc_cnt;
    repeat (20) tick();
    chk("bp_accepts", acc_cnt - acc0, RSP_DEPTH);
    chk("bp_stall", 32'(bus.req_ready), 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_cycle_ready", 32'(bus.req_ready), 0);
    tick();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_regrant", 32'(|bus.req_ready), 1);
    repeat (10) tick();
    chk("bp_accepts_after_pop", acc_cnt - acc0, RSP_DEPTH + 1);
    chk("bp_err", 32'(bus.err_flag), 0);
    drain("bp_drain");

`ifdef FP_ZERO_BYPASS_EN
    // Zero-exponent operand: no issue, signed zero comes back with normal latency.
    bus.rsp_ready = 1'b1;
    set_ops(0, 32'h80000000, 32'h40000000);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    t_acc = cyc;
    tick();
    bus.req_valid = '0;
    saw = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      if (bus.mul_in_valid) saw = 1'b1;
      n++;
    end
    chk("byp_no_issue", 32'(saw), 0);
    chk("byp_mul_a", bus.mul_a, 0);
    chk("byp_latency", cyc - t_acc, MUL_LATENCY + 2);
    drain("byp_drain");
    chk("byp_err", 32'(bus.err_flag), 0);
`endif

    // Spurious multiplier strobe with nothing in flight.
    chk("spur_pre", 32'(bus.err_flag), 0);
    inj = 1'b1;
    @(negedge clk);
    chk("spur_not_early", 32'(bus.err_flag), 0);
    @(negedge clk);
    chk("spur_err", 32'(bus.err_flag), 1);
    repeat (5) tick();
    chk("spur_hold", 32'(bus.err_flag), 1);

    // Reset clears the sticky flag, then reset again with three ops in flight.
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_clears_err", 32'(bus.err_flag), 0);
    tick();
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    repeat (3) tick();
    bus.req_valid = '0;
    rstn = 1'b0;
    tick();
    check_all_zero("midrst");
    chk("midrst_credit", 32'(dut.credit_q), 0);
    sb.delete();
    rstn = 1'b1;
    bus.req_valid = '1;
    @(negedge clk);
    chk("midrst_first_grant", 32'(bus.req_ready), 32'h1);
    tick();
    drain("midrst_drain");
    chk("midrst_late_err", 32'(bus.err_flag), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    chk("watchdog_timeout", 32'd1, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
